// File: rtl/sprite_blitter.sv
// Sprite blitter: walks a sprite in raster order out of a synchronous ROM and presents each
// opaque, on-screen texel to the SRAM controller's hidden-frame write port.
module sprite_blitter #(
  parameter int unsigned ROM_AW      = 14,
  parameter logic [15:0] TRANSPARENT = 16'hF81F,
  parameter logic [9:0]  PARK_X      = 10'h3FF,
  parameter int unsigned SCREEN_W    = 640,
  parameter int unsigned SCREEN_H    = 480
) (
  input  logic              sram_clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [9:0]        req_x,
  input  logic [9:0]        req_y,
  input  logic [6:0]        req_w,
  input  logic [6:0]        req_h,
  input  logic [ROM_AW-1:0] req_base,
  input  logic              frame_abort,
  output logic [ROM_AW-1:0] rom_addr,
  input  logic [15:0]       rom_data,
  input  logic              write_slot,
  output logic [9:0]        program_x,
  output logic [9:0]        program_y,
  output logic [15:0]       program_data,
  output logic              busy,
  output logic              done
);

  localparam logic [10:0] ScreenWL = 11'(SCREEN_W);
  localparam logic [10:0] ScreenHL = 11'(SCREEN_H);

  typedef enum logic [2:0] {StIdle, StFetch, StEval, StPresent, StDone} state_e;

  state_e            state_q, state_d;
  logic [9:0]        x0_q, x0_d, y0_q, y0_d;
  logic [6:0]        w_q, w_d, h_q, h_d;
  logic [6:0]        col_q, col_d, row_q, row_d;
  logic [ROM_AW-1:0] rom_addr_q, rom_addr_d;
  logic [9:0]        prog_x_q, prog_x_d, prog_y_q, prog_y_d;
  logic [15:0]       prog_data_q, prog_data_d;
  logic              done_q, done_d;
  logic              advance, last_texel, skip;
  logic [10:0]       px, py;

  // 11-bit sums so an origin near the edge cannot wrap back on-screen.
  assign px = {1'b0, x0_q} + {4'd0, col_q};
  assign py = {1'b0, y0_q} + {4'd0, row_q};
  assign skip = (rom_data == TRANSPARENT) || (px >= ScreenWL) || (py >= ScreenHL);
  assign last_texel = (col_q == w_q - 7'd1) && (row_q == h_q - 7'd1);

  always_comb begin
    state_d     = state_q;
    x0_d        = x0_q;
    y0_d        = y0_q;
    w_d         = w_q;
    h_d         = h_q;
    col_d       = col_q;
    row_d       = row_q;
    rom_addr_d  = rom_addr_q;
    prog_x_d    = prog_x_q;
    prog_y_d    = prog_y_q;
    prog_data_d = prog_data_q;
    done_d      = 1'b0;
    advance     = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (req_valid) begin
          x0_d       = req_x;
          y0_d       = req_y;
          w_d        = req_w;
          h_d        = req_h;
          col_d      = 7'd0;
          row_d      = 7'd0;
          rom_addr_d = req_base;
          state_d    = (req_w == 7'd0 || req_h == 7'd0) ? StDone : StFetch;
        end
      end
      StFetch: state_d = StEval;
      StEval: begin
        if (skip) begin
          advance = 1'b1;
        end else begin
          prog_x_d    = px[9:0];
          prog_y_d    = py[9:0];
          prog_data_d = rom_data;
          state_d     = StPresent;
        end
      end
      StPresent: begin
        if (write_slot) begin
          prog_x_d    = PARK_X;
          prog_y_d    = 10'd0;
          prog_data_d = 16'd0;
          advance     = 1'b1;
        end
      end
      StDone: begin
        done_d  = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    if (advance) begin
      rom_addr_d = rom_addr_q + 1'b1;
      if (col_q == w_q - 7'd1) begin
        col_d = 7'd0;
        row_d = row_q + 7'd1;
      end else begin
        col_d = col_q + 7'd1;
      end
      state_d = last_texel ? StDone : StFetch;
    end

    // Abort wins over a slot handshake and over completion.
    if (frame_abort && state_q != StIdle) begin
      state_d     = StIdle;
      prog_x_d    = PARK_X;
      prog_y_d    = 10'd0;
      prog_data_d = 16'd0;
      done_d      = 1'b0;
    end
  end

  always_ff @(posedge sram_clk or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      x0_q        <= '0;
      y0_q        <= '0;
      w_q         <= '0;
      h_q         <= '0;
      col_q       <= '0;
      row_q       <= '0;
      rom_addr_q  <= '0;
      prog_x_q    <= PARK_X;
      prog_y_q    <= '0;
      prog_data_q <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      x0_q        <= x0_d;
      y0_q        <= y0_d;
      w_q         <= w_d;
      h_q         <= h_d;
      col_q       <= col_d;
      row_q       <= row_d;
      rom_addr_q  <= rom_addr_d;
      prog_x_q    <= prog_x_d;
      prog_y_q    <= prog_y_d;
      prog_data_q <= prog_data_d;
      done_q      <= done_d;
    end
  end

  assign req_ready    = (state_q == StIdle);
  assign busy         = (state_q != StIdle);
  assign done         = done_q;
  assign rom_addr     = rom_addr_q;
  assign program_x    = prog_x_q;
  assign program_y    = prog_y_q;
  assign program_data = prog_data_q;

endmodule
